// File: rtl/dbg_cpu_ctrl_pkg.sv
// Shared types, default widths and helpers for the debug CPU access controller.
package dbg_cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DBG_CPU_ADDR_W    = 16;
  localparam int DBG_CPU_DATA_W    = 32;
  localparam int DBG_CPU_MAX_CORES = 32;

  // Isolates the least significant set bit; zero in gives zero out.
  function automatic logic [DBG_CPU_MAX_CORES-1:0] lowest_one(
    input logic [DBG_CPU_MAX_CORES-1:0] mask
  );
    return mask & (~mask + DBG_CPU_MAX_CORES'(1));
  endfunction

endpackage

// File: rtl/dbg_cpu_ctrl_timeout.sv
// Saturating access timer: counts enabled cycles and flags the cycle that
// completes TIMEOUT_CYCLES of waiting.
module dbg_cpu_ctrl_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  // Count enabled cycles, holding at the limit so the counter cannot wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // The current enabled cycle is the last one allowed before abort.
  assign expired_o = en_i && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/dbg_cpu_access_ctrl.sv
// Sequences single-requester debug accesses onto per-core CPU debug ports:
// single-beat reads to the lowest masked core, broadcast writes to all masked
// cores, each strobe held until ack or timeout, one response per request.
module dbg_cpu_access_ctrl
  import dbg_cpu_ctrl_pkg::*;
#(
  parameter int NB_CORES       = 1,
  parameter int ADDR_WIDTH     = DBG_CPU_ADDR_W,
  parameter int DATA_WIDTH     = DBG_CPU_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [NB_CORES-1:0]            req_core_mask_i,
  input  logic                           req_we_i,
  input  logic [ADDR_WIDTH-1:0]          req_addr_i,
  input  logic [DATA_WIDTH-1:0]          req_wdata_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                           rsp_err_o,
  output logic [NB_CORES-1:0]            rsp_timeout_mask_o,
  output logic [NB_CORES*ADDR_WIDTH-1:0] cpu_addr_o,
  output logic [NB_CORES*DATA_WIDTH-1:0] cpu_data_o,
  output logic [NB_CORES-1:0]            cpu_stb_o,
  output logic [NB_CORES-1:0]            cpu_we_o,
  input  logic [NB_CORES*DATA_WIDTH-1:0] cpu_data_i,
  input  logic [NB_CORES-1:0]            cpu_ack_i
);

  state_e                r_state;
  logic [NB_CORES-1:0]   r_pending;
  logic [NB_CORES-1:0]   r_tmo_mask;
  logic                  r_we;
  logic                  r_err;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_accept;
  logic                  w_expired;
  logic                  w_in_wait;
  logic [NB_CORES-1:0]   w_read_mask;
  logic [NB_CORES-1:0]   w_eff_mask;
  logic [NB_CORES-1:0]   w_ack_hit;
  logic [NB_CORES-1:0]   w_pending_nxt;
  logic [DATA_WIDTH-1:0] w_ack_data;

  assign req_ready_o = (r_state == IDLE) && !rst_i;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_in_wait   = (r_state == WAIT);

  // Reads target exactly one core so the returned data is unambiguous.
  assign w_read_mask = NB_CORES'(lowest_one(DBG_CPU_MAX_CORES'(req_core_mask_i)));
  assign w_eff_mask  = req_we_i ? req_core_mask_i : w_read_mask;

  // Acks only matter on cores still waiting; stray acks are masked off here.
  assign w_ack_hit     = cpu_ack_i & r_pending;
  assign w_pending_nxt = r_pending & ~cpu_ack_i;

  // Select read data from whichever pending core acknowledged this cycle.
  always_comb begin
    w_ack_data = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (w_ack_hit[i]) begin
        w_ack_data = cpu_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  dbg_cpu_ctrl_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (w_accept),
    .en_i     (w_in_wait),
    .expired_o(w_expired)
  );

  // Access sequencer: accept, wait for acks or timeout, then hold the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_tmo_mask  <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr     <= req_addr_i;
            r_wdata    <= req_wdata_i;
            r_we       <= req_we_i;
            r_rdata    <= '0;
            r_tmo_mask <= '0;
            if (w_eff_mask == '0) begin
              r_err       <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_err     <= 1'b0;
              r_pending <= w_eff_mask;
              r_state   <= WAIT;
            end
          end
        end
        WAIT: begin
          r_pending <= w_pending_nxt;
          if (!r_we && (w_ack_hit != '0)) begin
            r_rdata <= w_ack_data;
          end
          // Completion wins over expiry when the final ack lands on the last cycle.
          if (w_pending_nxt == '0) begin
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (w_expired) begin
            r_pending   <= '0;
            r_tmo_mask  <= w_pending_nxt;
            r_err       <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o        = r_rsp_valid;
  assign rsp_rdata_o        = r_rdata;
  assign rsp_err_o          = r_err;
  assign rsp_timeout_mask_o = r_tmo_mask;

  assign cpu_stb_o  = r_pending;
  assign cpu_we_o   = {NB_CORES{r_we}};
  assign cpu_addr_o = {NB_CORES{r_addr}};
  assign cpu_data_o = {NB_CORES{r_wdata}};

endmodule
